// File: rtl/writeback_stage.sv
// Final pipeline stage: retires ALU results to the register file and sequences
// the data-memory read for loads, stalling execute while a load is outstanding.
module writeback_stage #(
    parameter int D_SIZE = 32,
    parameter int A_SIZE = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [1:0]        ex_op_type_i,
    input  logic [2:0]        ex_destination_i,
    input  logic [D_SIZE-1:0] ex_result_i,
    output logic              mem_read_en_o,
    output logic [A_SIZE-1:0] mem_address_o,
    input  logic [D_SIZE-1:0] mem_data_in_i,
    input  logic              mem_data_valid_i,
    output logic              r2_write_en_o,
    output logic [2:0]        r2_destination_o,
    output logic [D_SIZE-1:0] write_back_o,
    output logic              load_pending_o,
    output logic [2:0]        load_dest_o,
    output logic [CNT_W-1:0]  retired_count_o
);

    // state     | meaning
    // IDLE      | accepting instructions from execute
    // LOAD_WAIT | load issued, waiting for mem_data_valid; execute stalled
    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] OP_ALU  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;

    state_t              state_q;
    logic                mem_read_en_q;
    logic [A_SIZE-1:0]   mem_address_q;
    logic                r2_write_en_q;
    logic [2:0]          r2_destination_q;
    logic [D_SIZE-1:0]   write_back_q;
    logic                load_pending_q;
    logic [2:0]          load_dest_q;
    logic [CNT_W-1:0]    retired_count_q;

    assign ex_ready_o       = (state_q == IDLE);
    assign mem_read_en_o    = mem_read_en_q;
    assign mem_address_o    = mem_address_q;
    assign r2_write_en_o    = r2_write_en_q;
    assign r2_destination_o = r2_destination_q;
    assign write_back_o     = write_back_q;
    assign load_pending_o   = load_pending_q;
    assign load_dest_o      = load_dest_q;
    assign retired_count_o  = retired_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            mem_read_en_q    <= 1'b0;
            mem_address_q    <= '0;
            r2_write_en_q    <= 1'b0;
            r2_destination_q <= '0;
            write_back_q     <= '0;
            load_pending_q   <= 1'b0;
            load_dest_q      <= '0;
            retired_count_q  <= '0;
        end else begin
            // Strobes are single-cycle pulses; data outputs hold their last value.
            mem_read_en_q <= 1'b0;
            r2_write_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid_i) begin
                        if (ex_op_type_i == OP_ALU) begin
                            r2_write_en_q    <= 1'b1;
                            r2_destination_q <= ex_destination_i;
                            write_back_q     <= ex_result_i;
                            retired_count_q  <= retired_count_q + 1'b1;
                        end else if (ex_op_type_i == OP_LOAD) begin
                            mem_read_en_q  <= 1'b1;
                            mem_address_q  <= ex_result_i[A_SIZE-1:0];
                            load_pending_q <= 1'b1;
                            load_dest_q    <= ex_destination_i;
                            state_q        <= LOAD_WAIT;
                        end
                    end
                end
                LOAD_WAIT: begin
                    // Sampled already in the strobe cycle so zero-wait memory works.
                    if (mem_data_valid_i) begin
                        r2_write_en_q    <= 1'b1;
                        r2_destination_q <= load_dest_q;
                        write_back_q     <= mem_data_in_i;
                        load_pending_q   <= 1'b0;
                        retired_count_q  <= retired_count_q + 1'b1;
                        state_q          <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

    localparam int D_SIZE = 32;
    localparam int A_SIZE = 10;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              ex_valid;
    logic              ex_ready;
    logic [1:0]        ex_op_type;
    logic [2:0]        ex_destination;
    logic [D_SIZE-1:0] ex_result;
    logic              mem_read_en;
    logic [A_SIZE-1:0] mem_address;
    logic [D_SIZE-1:0] mem_data_in;
    logic              mem_data_valid;
    logic              r2_write_en;
    logic [2:0]        r2_destination;
    logic [D_SIZE-1:0] write_back;
    logic              load_pending;
    logic [2:0]        load_dest;
    logic [CNT_W-1:0]  retired_count;

    int n_tests = 0;
    int n_fail  = 0;

    writeback_stage #(.D_SIZE(D_SIZE), .A_SIZE(A_SIZE), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid_i       (ex_valid),
        .ex_ready_o       (ex_ready),
        .ex_op_type_i     (ex_op_type),
        .ex_destination_i (ex_destination),
        .ex_result_i      (ex_result),
        .mem_read_en_o    (mem_read_en),
        .mem_address_o    (mem_address),
        .mem_data_in_i    (mem_data_in),
        .mem_data_valid_i (mem_data_valid),
        .r2_write_en_o    (r2_write_en),
        .r2_destination_o (r2_destination),
        .write_back_o     (write_back),
        .load_pending_o   (load_pending),
        .load_dest_o      (load_dest),
        .retired_count_o  (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] dst,
                         input logic [D_SIZE-1:0] res);
        ex_valid       = v;
        ex_op_type     = op;
        ex_destination = dst;
        ex_result      = res;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 3'd0, '0);
        mem_data_in    = '0;
        mem_data_valid = 1'b0;
        #12;
        chk("rst_ready", 64'(ex_ready), 64'd1);
        chk("rst_we", 64'(r2_write_en), 64'd0);
        chk("rst_wb", 64'(write_back), 64'd0);
        chk("rst_cnt", 64'(retired_count), 64'd0);
        chk("rst_pend", 64'(load_pending), 64'd0);
        chk("rst_rden", 64'(mem_read_en), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: single ALU op
        drive(1'b1, 2'b01, 3'd3, 32'hDEADBEEF);
        step();
        drive(1'b0, 2'b00, 3'd0, '0);
        chk("t1_we", 64'(r2_write_en), 64'd1);
        chk("t1_dst", 64'(r2_destination), 64'd3);
        chk("t1_wb", 64'(write_back), 64'hDEADBEEF);
        chk("t1_cnt", 64'(retired_count), 64'd1);
        step();
        chk("t1_we_pulse", 64'(r2_write_en), 64'd0);
        chk("t1_wb_hold", 64'(write_back), 64'hDEADBEEF);

        // 2: back-to-back ALU ops
        drive(1'b1, 2'b01, 3'd1, 32'h11111111);
        step();
        chk("t2_we1", 64'(r2_write_en), 64'd1);
        chk("t2_dst1", 64'(r2_destination), 64'd1);
        chk("t2_rdy1", 64'(ex_ready), 64'd1);
        drive(1'b1, 2'b01, 3'd2, 32'h22222222);
        step();
        chk("t2_we2", 64'(r2_write_en), 64'd1);
        chk("t2_dst2", 64'(r2_destination), 64'd2);
        chk("t2_wb2", 64'(write_back), 64'h22222222);
        drive(1'b1, 2'b01, 3'd3, 32'h33333333);
        step();
        drive(1'b0, 2'b00, 3'd0, '0);
        chk("t2_we3", 64'(r2_write_en), 64'd1);
        chk("t2_dst3", 64'(r2_destination), 64'd3);
        chk("t2_wb3", 64'(write_back), 64'h33333333);
        chk("t2_cnt", 64'(retired_count), 64'd4);
        step();

        // 3: load with three-cycle memory latency; ex inputs ignored while waiting
        drive(1'b1, 2'b10, 3'd5, 32'hFFFFF123);
        step();
        drive(1'b1, 2'b01, 3'd7, 32'h77777777);
        chk("t3_rden", 64'(mem_read_en), 64'd1);
        chk("t3_addr", 64'(mem_address), 64'h123);
        chk("t3_pend", 64'(load_pending), 64'd1);
        chk("t3_ldst", 64'(load_dest), 64'd5);
        chk("t3_rdy0", 64'(ex_ready), 64'd0);
        for (int i = 1; i <= 2; i++) begin
            step();
            chk("t3_wait_rden", 64'(mem_read_en), 64'd0);
            chk("t3_wait_rdy", 64'(ex_ready), 64'd0);
            chk("t3_wait_pend", 64'(load_pending), 64'd1);
            chk("t3_wait_we", 64'(r2_write_en), 64'd0);
            chk("t3_addr_hold", 64'(mem_address), 64'h123);
        end
        step();
        drive(1'b0, 2'b00, 3'd0, '0);
        mem_data_valid = 1'b1;
        mem_data_in    = 32'h000055AA;
        chk("t3_last_wait_we", 64'(r2_write_en), 64'd0);
        step();
        mem_data_valid = 1'b0;
        chk("t3_we", 64'(r2_write_en), 64'd1);
        chk("t3_dst", 64'(r2_destination), 64'd5);
        chk("t3_wb", 64'(write_back), 64'h55AA);
        chk("t3_rdy1", 64'(ex_ready), 64'd1);
        chk("t3_pend0", 64'(load_pending), 64'd0);
        chk("t3_cnt", 64'(retired_count), 64'd5);
        step();

        // 4: zero-wait memory
        drive(1'b1, 2'b10, 3'd6, 32'h0000002A);
        step();
        drive(1'b0, 2'b00, 3'd0, '0);
        chk("t4_rden", 64'(mem_read_en), 64'd1);
        chk("t4_addr", 64'(mem_address), 64'h2A);
        mem_data_valid = 1'b1;
        mem_data_in    = 32'h0000CAFE;
        step();
        mem_data_valid = 1'b0;
        chk("t4_we", 64'(r2_write_en), 64'd1);
        chk("t4_dst", 64'(r2_destination), 64'd6);
        chk("t4_wb", 64'(write_back), 64'hCAFE);
        chk("t4_cnt", 64'(retired_count), 64'd6);
        step();

        // 5: reset during LOAD_WAIT abandons the load
        drive(1'b1, 2'b10, 3'd4, 32'h00000010);
        step();
        drive(1'b0, 2'b00, 3'd0, '0);
        chk("t5_pend", 64'(load_pending), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_rdy", 64'(ex_ready), 64'd1);
        chk("t5_rst_pend", 64'(load_pending), 64'd0);
        chk("t5_rst_wb", 64'(write_back), 64'd0);
        chk("t5_rst_cnt", 64'(retired_count), 64'd0);
        chk("t5_rst_addr", 64'(mem_address), 64'd0);
        mem_data_valid = 1'b1;
        mem_data_in    = 32'hBAD0BAD0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_we", 64'(r2_write_en), 64'd0);
            chk("t5_cnt0", 64'(retired_count), 64'd0);
        end
        mem_data_valid = 1'b0;

        // 6: non-writing ops and stray mem_data_valid in IDLE
        drive(1'b1, 2'b00, 3'd1, 32'h1);
        step();
        chk("t6_op00_we", 64'(r2_write_en), 64'd0);
        chk("t6_op00_rden", 64'(mem_read_en), 64'd0);
        drive(1'b1, 2'b11, 3'd2, 32'h2);
        step();
        chk("t6_op11_we", 64'(r2_write_en), 64'd0);
        chk("t6_op11_rden", 64'(mem_read_en), 64'd0);
        chk("t6_op11_rdy", 64'(ex_ready), 64'd1);
        drive(1'b0, 2'b00, 3'd0, '0);
        mem_data_valid = 1'b1;
        step();
        mem_data_valid = 1'b0;
        chk("t6_idle_mdv_we", 64'(r2_write_en), 64'd0);
        chk("t6_cnt", 64'(retired_count), 64'd0);

        // 6b: count wrap
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 2'b01, 3'(i), 32'(i));
            step();
        end
        chk("t6_cnt_max", 64'(retired_count), 64'hFFFF);
        drive(1'b1, 2'b01, 3'd0, 32'h00001234);
        step();
        drive(1'b0, 2'b00, 3'd0, '0);
        chk("t6_wrap_cnt", 64'(retired_count), 64'd0);
        chk("t6_r0_we", 64'(r2_write_en), 64'd1);
        chk("t6_r0_dst", 64'(r2_destination), 64'd0);
        chk("t6_r0_wb", 64'(write_back), 64'h1234);
        step();
        chk("t6_end_we", 64'(r2_write_en), 64'd0);
        chk("t6_end_wb", 64'(write_back), 64'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
